// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
package seg_scan_pkg;

    // Active-low glyphs, dp bit forced high
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;

    localparam logic [3:0] DIGIT_BAD = 4'hF;

    // Digit positions; also the anode bit that selects them
    localparam logic [1:0] POS_S0 = 2'd0;
    localparam logic [1:0] POS_S1 = 2'd1;
    localparam logic [1:0] POS_M0 = 2'd2;
    localparam logic [1:0] POS_M1 = 2'd3;

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETTLE,
        S_CAPTURED
    } scan_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational active-low 7-segment glyph to BCD digit decoder (dp ignored).
module seg7_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [3:0] digit,
    output logic       bad
);

    logic [7:0] pat;

    // Map the glyph with dp forced off onto its digit; anything else is bad
    always_comb begin
        pat   = pattern | 8'h80;
        digit = DIGIT_BAD;
        bad   = 1'b0;
        case (pat)
            GLYPH_0: digit = 4'd0;
            GLYPH_1: digit = 4'd1;
            GLYPH_2: digit = 4'd2;
            GLYPH_3: digit = 4'd3;
            GLYPH_4: digit = 4'd4;
            GLYPH_5: digit = 4'd5;
            GLYPH_6: digit = 4'd6;
            GLYPH_7: digit = 4'd7;
            GLYPH_8: digit = 4'd8;
            GLYPH_9: digit = 4'd9;
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed active-low 7-segment bus, rejects scan ghosts and
// reassembles the four displayed digits into an MM:SS frame.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned STALL_CYCLES  = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg,
    input  logic [3:0] ad,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       frame_valid,
    output logic [7:0] frame_count,
    output logic       glyph_err,
    output logic       stalled
);

    localparam int unsigned SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned STW = $clog2(STALL_CYCLES + 1);
    localparam logic [SW-1:0]  SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [STW-1:0] STALL_MAX  = STW'(STALL_CYCLES);

    logic [11:0]      pair_q, pair_d;
    logic [11:0]      prev_q, prev_d;
    scan_state_e      state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [3:0]       mask_q, mask_d, cap_bit;
    logic [3:0][3:0]  stage_q, stage_d;
    logic [3:0][3:0]  out_q, out_d;
    logic             fv_q, fv_d;
    logic [7:0]       fc_q, fc_d;
    logic             gerr_q, gerr_d;
    logic [STW-1:0]   stall_q, stall_d;

    logic             anode_ok;
    logic [1:0]       pos;
    logic             changed;
    logic             capture;
    logic             frame_done;
    logic [3:0]       cap_digit;
    logic             cap_bad;

    seg7_glyph_decode u_decode (
        .pattern (pair_q[7:0]),
        .digit   (cap_digit),
        .bad     (cap_bad)
    );

    // Exactly one low anode selects a position; anything else is invalid
    always_comb begin
        anode_ok = 1'b1;
        pos      = POS_S0;
        case (pair_q[11:8])
            4'b1110: pos = POS_S0;
            4'b1101: pos = POS_S1;
            4'b1011: pos = POS_M0;
            4'b0111: pos = POS_M1;
            default: anode_ok = 1'b0;
        endcase
    end

    // Settle FSM: count unchanged samples and capture once per stable pair
    always_comb begin
        pair_d  = {ad, seg};
        prev_d  = pair_q;
        changed = (pair_q != prev_q);
        cnt_inc = cnt_q + SW'(1);
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_WAIT: begin
                cnt_d = '0;
                if (anode_ok) begin
                    state_d = S_SETTLE;
                    cnt_d   = SW'(1);
                end
            end
            S_SETTLE: begin
                if (changed) begin
                    if (anode_ok) begin
                        cnt_d = SW'(1);
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end else if (cnt_inc == SETTLE_MAX) begin
                    capture = 1'b1;
                    state_d = S_CAPTURED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_CAPTURED: begin
                cnt_d = '0;
                if (changed) begin
                    if (anode_ok) begin
                        state_d = S_SETTLE;
                        cnt_d   = SW'(1);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Staging, frame completion, error flag and stall supervision
    always_comb begin
        frame_done = (mask_q == 4'hF);
        cap_bit    = capture ? (4'b0001 << pos) : 4'b0000;
        // A capture landing on the completion cycle starts the next frame's mask
        mask_d     = frame_done ? cap_bit : (mask_q | cap_bit);
        out_d      = frame_done ? stage_q : out_q;
        fv_d       = frame_done;
        fc_d       = frame_done ? fc_q + 8'd1 : fc_q;
        stage_d    = stage_q;
        gerr_d     = gerr_q;
        if (capture) begin
            stage_d[pos] = cap_digit;
            gerr_d       = gerr_q | cap_bad;
        end
        if (capture) begin
            stall_d = '0;
        end else if (stall_q == STALL_MAX) begin
            stall_d = stall_q;
        end else begin
            stall_d = stall_q + STW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_q  <= '0;
            prev_q  <= '0;
            state_q <= S_WAIT;
            cnt_q   <= '0;
            mask_q  <= '0;
            stage_q <= '0;
            out_q   <= '0;
            fv_q    <= 1'b0;
            fc_q    <= '0;
            gerr_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            pair_q  <= pair_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            fv_q    <= fv_d;
            fc_q    <= fc_d;
            gerr_q  <= gerr_d;
            stall_q <= stall_d;
        end
    end

    assign m1          = out_q[POS_M1];
    assign m0          = out_q[POS_M0];
    assign s1          = out_q[POS_S1];
    assign s0          = out_q[POS_S0];
    assign frame_valid = fv_q;
    assign frame_count = fc_q;
    assign glyph_err   = gerr_q;
    assign stalled     = (stall_q == STALL_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a run-length based reference model.
module tb_seg_scan_decoder;

    localparam int SETTLE = 16;
    localparam int STALL  = 256;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seg_i = 8'hFF;
    logic [3:0] ad_i  = 4'hF;
    logic [3:0] m1, m0, s1, s0;
    logic       frame_valid;
    logic [7:0] frame_count;
    logic       glyph_err;
    logic       stalled;

    int checks = 0;
    int errors = 0;
    int fv_pulses = 0;

    logic [7:0] glyph_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .STALL_CYCLES  (STALL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg_i),
        .ad          (ad_i),
        .m1          (m1),
        .m0          (m0),
        .s1          (s1),
        .s0          (s0),
        .frame_valid (frame_valid),
        .frame_count (frame_count),
        .glyph_err   (glyph_err),
        .stalled     (stalled)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int dec(input logic [7:0] p);
        for (int i = 0; i < 10; i++)
            if ((p | 8'h80) == glyph_tbl[i]) return i;
        return 15;
    endfunction

    function automatic int apos(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    logic [11:0] mp_last;
    int          m_run;
    logic [3:0]  m_mask;
    int          m_stage [4];
    int          m_out   [4];
    bit          m_fv;
    int          m_fc;
    bit          m_gerr;
    int          m_stall;
    int          mp;
    bit          mcap;

    // A capture happens one edge after a valid pair has been sampled SETTLE times in a row
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mp_last = '0;
            m_run   = 1;
            m_mask  = '0;
            for (int i = 0; i < 4; i++) begin
                m_stage[i] = 0;
                m_out[i]   = 0;
            end
            m_fv    = 0;
            m_fc    = 0;
            m_gerr  = 0;
            m_stall = 0;
        end else begin
            mp   = apos(mp_last[11:8]);
            mcap = (m_run == SETTLE) && (mp >= 0);
            if (m_mask == 4'hF) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_stage[i];
                m_fv   = 1;
                m_fc   = (m_fc + 1) % 256;
                m_mask = mcap ? 4'(1 << mp) : 4'h0;
            end else begin
                m_fv = 0;
                if (mcap) m_mask = m_mask | 4'(1 << mp);
            end
            if (mcap) begin
                m_stage[mp] = dec(mp_last[7:0]);
                if (m_stage[mp] == 15) m_gerr = 1;
                m_stall = 0;
            end else if (m_stall < STALL) begin
                m_stall++;
            end
            if ({ad_i, seg_i} == mp_last) begin
                if (m_run < 1000000) m_run++;
            end else begin
                m_run = 1;
            end
            mp_last = {ad_i, seg_i};
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("m1", m1, m_out[3]);
            chk("m0", m0, m_out[2]);
            chk("s1", s1, m_out[1]);
            chk("s0", s0, m_out[0]);
            chk("frame_valid", frame_valid, m_fv);
            chk("frame_count", frame_count, m_fc);
            chk("glyph_err", glyph_err, m_gerr);
            chk("stalled", stalled, m_stall == STALL);
            if (frame_valid) fv_pulses++;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [3:0] an(input int p);
        return ~(4'b0001 << p);
    endfunction

    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
        repeat (n) begin
            @(negedge clk);
            ad_i  = a;
            seg_i = s;
        end
    endtask

    task automatic scan(input int d3, input int d2, input int d1, input int d0,
                        input int n, input bit ghost);
        int dig [4];
        logic [7:0] prev_seg;
        dig[3] = d3; dig[2] = d2; dig[1] = d1; dig[0] = d0;
        prev_seg = seg_i;
        for (int p = 3; p >= 0; p--) begin
            if (ghost) drive(an(p), prev_seg, 3);
            drive(an(p), glyph_tbl[dig[p]], n);
            prev_seg = glyph_tbl[dig[p]];
        end
    endtask

    task automatic chk_digits(input string tag, input int e3, input int e2, input int e1, input int e0);
        chk({tag, "_m1"}, m1, e3);
        chk({tag, "_m0"}, m0, e2);
        chk({tag, "_s1"}, s1, e1);
        chk({tag, "_s0"}, s0, e0);
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_digits("rst", 0, 0, 0, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_gerr", glyph_err, 0);
        chk("rst_stall", stalled, 0);
        reset = 1'b1;
        drive(4'hF, 8'hFF, 2);

        // clean scan
        scan(1, 2, 5, 9, 64, 1'b0);
        @(negedge clk);
        chk_digits("clean", 1, 2, 5, 9);
        chk("clean_fc", frame_count, 1);
        chk("clean_pulses", fv_pulses, 1);
        chk("clean_gerr", glyph_err, 0);

        // ghosted scan
        scan(6, 7, 3, 0, 64, 1'b1);
        @(negedge clk);
        chk_digits("ghost", 6, 7, 3, 0);
        chk("ghost_fc", frame_count, 2);
        chk("ghost_pulses", fv_pulses, 2);
        chk("ghost_gerr", glyph_err, 0);

        // undecodable glyph on s0
        drive(an(3), glyph_tbl[4], 64);
        drive(an(2), glyph_tbl[8], 64);
        drive(an(1), glyph_tbl[1], 64);
        drive(an(0), 8'hA5, 64);
        @(negedge clk);
        chk_digits("bad", 4, 8, 1, 15);
        chk("bad_gerr", glyph_err, 1);
        chk("bad_fc", frame_count, 3);
        scan(2, 3, 4, 5, 20, 1'b0);
        @(negedge clk);
        chk_digits("after_bad", 2, 3, 4, 5);
        chk("sticky_gerr", glyph_err, 1);

        // s0 captured twice before the rest
        drive(an(0), glyph_tbl[3], 20);
        drive(an(0), glyph_tbl[7], 20);
        drive(an(1), glyph_tbl[4], 20);
        drive(an(2), glyph_tbl[3], 20);
        drive(an(3), glyph_tbl[0], 20);
        @(negedge clk);
        chk_digits("twice", 0, 3, 4, 7);
        chk("twice_fc", frame_count, 5);

        // two anodes low: no capture, stall
        drive(4'b0011, glyph_tbl[0], 300);
        chk("stall_set", stalled, 1);
        chk("stall_fc", frame_count, 5);
        scan(9, 8, 7, 6, 20, 1'b0);
        @(negedge clk);
        chk("stall_clear", stalled, 0);
        chk_digits("stall_scan", 9, 8, 7, 6);
        chk("stall_scan_fc", frame_count, 6);

        // run to frame_count wrap
        for (int f = 0; f < 250; f++)
            scan(f % 10, (f + 1) % 10, (f + 2) % 10, (f + 3) % 10, 20, 1'b0);
        @(negedge clk);
        chk("wrap_fc", frame_count, 0);
        chk("wrap_pulses", fv_pulses, 256);
        chk_digits("wrap", 9, 0, 1, 2);

        // reset in the middle of a frame
        drive(an(3), glyph_tbl[8], 20);
        drive(an(2), glyph_tbl[8], 10);
        #2 reset = 1'b0;
        #1;
        chk_digits("midrst", 0, 0, 0, 0);
        chk("midrst_fv", frame_valid, 0);
        chk("midrst_fc", frame_count, 0);
        chk("midrst_gerr", glyph_err, 0);
        chk("midrst_stall", stalled, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // fresh frame needs all four positions
        drive(an(0), glyph_tbl[1], 20);
        drive(an(1), glyph_tbl[2], 20);
        drive(an(2), glyph_tbl[3], 20);
        @(negedge clk);
        chk("partial_fc", frame_count, 0);
        chk_digits("partial", 0, 0, 0, 0);
        drive(an(3), glyph_tbl[4], 20);
        @(negedge clk);
        chk("fresh_fc", frame_count, 1);
        chk_digits("fresh", 4, 3, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
